// File: rtl/dec8b10b_pkg.sv
// 8b/10b decode tables, disparity classes, running-disparity step and legal-K check.
package dec8b10b_pkg;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  localparam logic [4:0] K28_X = 5'd28;

  // x values whose D.x.A7 alternate (fghj 0111/1000) is a legal data symbol
  localparam logic [31:0] A7_X_MASK = 32'h0016_6800;  // 11,13,14,17,18,20
  // x values that form K.x.7 with the alternate 4b code
  localparam logic [31:0] K_X7_MASK = 32'h6880_0000;  // 23,27,29,30

  typedef enum logic [2:0] {
    DC_NEG,
    DC_NEU,
    DC_POS,
    DC_NEU_RDN,
    DC_NEU_RDP,
    DC_ILL
  } disp_cls_e;

  typedef struct packed {
    logic [4:0] val;
    logic       hit;
  } dec6_t;

  typedef struct packed {
    logic [2:0] val;
    logic       hit;
    logic       alt;
  } dec4_t;

  typedef struct packed {
    logic [7:0] data;
    disp_cls_e  cls6;
    disp_cls_e  cls4;
    logic       k;
    logic       miss;
  } lane_s1_t;

  function automatic int unsigned popc6(input logic [5:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 6; i++) n += 32'(v[i]);
    return n;
  endfunction

  // abcdei written a-first, as in the usual code tables
  function automatic dec6_t dec6b(input logic [5:0] abcdei);
    dec6_t r;
    r.val = '0;
    r.hit = 1'b1;
    case (abcdei)
      6'b100111, 6'b011000: r.val = 5'd0;
      6'b011101, 6'b100010: r.val = 5'd1;
      6'b101101, 6'b010010: r.val = 5'd2;
      6'b110001:            r.val = 5'd3;
      6'b110101, 6'b001010: r.val = 5'd4;
      6'b101001:            r.val = 5'd5;
      6'b011001:            r.val = 5'd6;
      6'b111000, 6'b000111: r.val = 5'd7;
      6'b111001, 6'b000110: r.val = 5'd8;
      6'b100101:            r.val = 5'd9;
      6'b010101:            r.val = 5'd10;
      6'b110100:            r.val = 5'd11;
      6'b001101:            r.val = 5'd12;
      6'b101100:            r.val = 5'd13;
      6'b011100:            r.val = 5'd14;
      6'b010111, 6'b101000: r.val = 5'd15;
      6'b011011, 6'b100100: r.val = 5'd16;
      6'b100011:            r.val = 5'd17;
      6'b010011:            r.val = 5'd18;
      6'b110010:            r.val = 5'd19;
      6'b001011:            r.val = 5'd20;
      6'b101010:            r.val = 5'd21;
      6'b011010:            r.val = 5'd22;
      6'b111010, 6'b000101: r.val = 5'd23;
      6'b110011, 6'b001100: r.val = 5'd24;
      6'b100110:            r.val = 5'd25;
      6'b010110:            r.val = 5'd26;
      6'b110110, 6'b001001: r.val = 5'd27;
      6'b001110:            r.val = 5'd28;
      6'b101110, 6'b010001: r.val = 5'd29;
      6'b011110, 6'b100001: r.val = 5'd30;
      6'b101011, 6'b010100: r.val = 5'd31;
      6'b001111, 6'b110000: r.val = K28_X;
      default:              r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic dec4_t dec4b(input logic [3:0] fghj);
    dec4_t r;
    r.val = '0;
    r.hit = 1'b1;
    r.alt = 1'b0;
    case (fghj)
      4'b1011, 4'b0100: r.val = 3'd0;
      4'b1001:          r.val = 3'd1;
      4'b0101:          r.val = 3'd2;
      4'b1100, 4'b0011: r.val = 3'd3;
      4'b1101, 4'b0010: r.val = 3'd4;
      4'b1010:          r.val = 3'd5;
      4'b0110:          r.val = 3'd6;
      4'b1110, 4'b0001: r.val = 3'd7;
      4'b0111, 4'b1000: begin
        r.val = 3'd7;
        r.alt = 1'b1;
      end
      default:          r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic disp_cls_e cls6b(input logic [5:0] abcdei);
    disp_cls_e c;
    case (popc6(abcdei))
      2:       c = DC_NEG;
      3: begin
        if (abcdei == 6'b111000)      c = DC_NEU_RDN;
        else if (abcdei == 6'b000111) c = DC_NEU_RDP;
        else                          c = DC_NEU;
      end
      4:       c = DC_POS;
      default: c = DC_ILL;
    endcase
    return c;
  endfunction

  function automatic disp_cls_e cls4b(input logic [3:0] fghj);
    disp_cls_e c;
    case (popc6({2'b00, fghj}))
      1:       c = DC_NEG;
      2: begin
        if (fghj == 4'b1100)      c = DC_NEU_RDN;
        else if (fghj == 4'b0011) c = DC_NEU_RDP;
        else                      c = DC_NEU;
      end
      3:       c = DC_POS;
      default: c = DC_ILL;
    endcase
    return c;
  endfunction

  // returns {disparity_error, next_rd}
  function automatic logic [1:0] rd_step(input disp_cls_e cls, input logic rd);
    logic err;
    logic nxt;
    err = 1'b0;
    nxt = rd;
    case (cls)
      DC_POS: begin
        err = (rd == RD_POS);
        nxt = RD_POS;
      end
      DC_NEG: begin
        err = (rd == RD_NEG);
        nxt = RD_NEG;
      end
      DC_NEU_RDN: err = (rd == RD_POS);
      DC_NEU_RDP: err = (rd == RD_NEG);
      default:    ;
    endcase
    return {err, nxt};
  endfunction

  function automatic logic k_legal(input logic [7:0] d);
    return (d[4:0] == K28_X) || ((d[7:5] == 3'd7) && K_X7_MASK[d[4:0]]);
  endfunction

endpackage

// File: rtl/dec8b10b_lane.sv
// Stage-1 lookup for one 10-bit lane: decoded byte, sub-block disparity classes,
// K flag and table-miss flag, registered when en is high.
module dec8b10b_lane
  import dec8b10b_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [9:0] sym,
  output lane_s1_t   s1_q
);

  lane_s1_t   s1_d;
  logic [5:0] abcdei;
  logic [3:0] fghj;
  logic [3:0] fghj_dec;
  logic       is_k28;
  logic       is_k28_rdp;
  logic       k_cand;
  dec6_t      r6;
  dec4_t      r4;

  // Table lookup and legality of the incoming symbol
  always_comb begin
    abcdei     = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
    fghj       = {sym[6], sym[7], sym[8], sym[9]};
    is_k28_rdp = (sym[5:0] == K28_5_RDP[5:0]);
    is_k28     = (sym[5:0] == K28_5_RDN[5:0]) || is_k28_rdp;
    // After the RD+ K28 6b form, the 4b code is the complement of the data form
    fghj_dec   = is_k28_rdp ? ~fghj : fghj;
    r6         = dec6b(abcdei);
    r4         = dec4b(fghj_dec);
    k_cand     = is_k28 | (r4.alt & K_X7_MASK[r6.val]);

    s1_d = s1_q;
    if (en) begin
      s1_d.data = {r4.val, r6.val};
      s1_d.cls6 = cls6b(abcdei);
      s1_d.cls4 = cls4b(fghj);
      s1_d.miss = ~r6.hit | ~r4.hit
                | (r4.alt & ~is_k28 & ~A7_X_MASK[r6.val] & ~K_X7_MASK[r6.val])
                | (k_cand & ~k_legal({r4.val, r6.val}));
      s1_d.k    = k_cand & ~s1_d.miss;
    end
  end

  // Stage-1 register
  always_ff @(posedge clk) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

endmodule

// File: rtl/dec8b10b_rd.sv
// Multi-lane 8b/10b decoder with running-disparity tracking, two-stage pipeline.
// Optional error counter (err_cnt_clr / err_cnt) when DEC8B10B_ERR_CNT_EN is defined.
module dec8b10b_rd
  import dec8b10b_pkg::*;
#(
  parameter int unsigned LANES   = 1,
  parameter int unsigned RD_INIT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [10*LANES-1:0]  data_in,
`ifdef DEC8B10B_ERR_CNT_EN
  input  logic                 err_cnt_clr,
  output logic [15:0]          err_cnt,
`endif
  output logic                 out_valid,
  output logic [8*LANES-1:0]   data_out,
  output logic [LANES-1:0]     k_out,
  output logic [LANES-1:0]     code_err,
  output logic [LANES-1:0]     disp_err,
  output logic                 rd_out
);

  localparam logic RD_RST = (RD_INIT != 0) ? RD_POS : RD_NEG;

  logic                s1_valid_q, s1_valid_d;
  lane_s1_t            s1_q [LANES];

  logic                out_valid_q, out_valid_d;
  logic [8*LANES-1:0]  data_out_q, data_out_d;
  logic [LANES-1:0]    k_out_q, k_out_d;
  logic [LANES-1:0]    code_err_q, code_err_d;
  logic [LANES-1:0]    disp_err_q, disp_err_d;
  logic                rd_q, rd_d;

  logic [8*LANES-1:0]  dat_c;
  logic [LANES-1:0]    k_c, ce_c, de_c;
  logic                rd_chain;
  logic [1:0]          st6, st4;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dec8b10b_lane u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (in_valid),
      .sym   (data_in[10*g +: 10]),
      .s1_q  (s1_q[g])
    );
  end

  // Stage-1 valid tracks in_valid
  always_comb begin
    s1_valid_d = in_valid;
  end

  // RD chain across lanes, 6b before 4b, lane 0 first
  always_comb begin
    rd_chain = rd_q;
    dat_c    = '0;
    k_c      = '0;
    ce_c     = '0;
    de_c     = '0;
    st6      = '0;
    st4      = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      st6             = rd_step(s1_q[i].cls6, rd_chain);
      st4             = rd_step(s1_q[i].cls4, st6[0]);
      rd_chain        = st4[0];
      de_c[i]         = st6[1] | st4[1];
      ce_c[i]         = s1_q[i].miss;
      dat_c[8*i +: 8] = s1_q[i].miss ? 8'h00 : s1_q[i].data;
      k_c[i]          = s1_q[i].k & ~s1_q[i].miss;
    end
  end

  // Stage-2 next state: load only on valid data, otherwise hold
  always_comb begin
    out_valid_d = s1_valid_q;
    data_out_d  = data_out_q;
    k_out_d     = k_out_q;
    code_err_d  = code_err_q;
    disp_err_d  = disp_err_q;
    rd_d        = rd_q;
    if (s1_valid_q) begin
      data_out_d = dat_c;
      k_out_d    = k_c;
      code_err_d = ce_c;
      disp_err_d = de_c;
      rd_d       = rd_chain;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      k_out_q     <= '0;
      code_err_q  <= '0;
      disp_err_q  <= '0;
      rd_q        <= RD_RST;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      k_out_q     <= k_out_d;
      code_err_q  <= code_err_d;
      disp_err_q  <= disp_err_d;
      rd_q        <= rd_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign k_out     = k_out_q;
  assign code_err  = code_err_q;
  assign disp_err  = disp_err_q;
  assign rd_out    = rd_q;

`ifdef DEC8B10B_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;
  int unsigned n_err;

  // Saturating count of errored lanes, updated together with the flags
  always_comb begin
    n_err = 0;
    for (int unsigned i = 0; i < LANES; i++) n_err += 32'(ce_c[i] | de_c[i]);
    err_sum   = {1'b0, err_cnt_q} + 17'(n_err);
    err_cnt_d = err_cnt_q;
    if (s1_valid_q) err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    if (err_cnt_clr) err_cnt_d = '0;
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_dec8b10b_rd.sv
// Directed table-driven bench for dec8b10b_rd (LANES=1 and LANES=2 instances).
module tb_dec8b10b_rd;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] data;
    logic       k;
    logic       ce;
    logic       de;
    logic       rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid1, in_valid2;
  logic [9:0]  data_in1;
  logic [19:0] data_in2;
  logic        out_valid1, out_valid2;
  logic [7:0]  data_out1;
  logic [15:0] data_out2;
  logic        k1, ce1, de1, rd1;
  logic [1:0]  k2, ce2, de2;
  logic        rd2;
`ifdef DEC8B10B_ERR_CNT_EN
  logic        clr1, clr2;
  logic [15:0] cnt1, cnt2;
`endif

  int checks = 0;
  int errors = 0;

  vec_t vecs [14];
  vec_t strm [4];

  always #5 clk = ~clk;

  dec8b10b_rd #(.LANES(1), .RD_INIT(0)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .data_in(data_in1),
`ifdef DEC8B10B_ERR_CNT_EN
    .err_cnt_clr(clr1), .err_cnt(cnt1),
`endif
    .out_valid(out_valid1), .data_out(data_out1), .k_out(k1),
    .code_err(ce1), .disp_err(de1), .rd_out(rd1)
  );

  dec8b10b_rd #(.LANES(2), .RD_INIT(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .data_in(data_in2),
`ifdef DEC8B10B_ERR_CNT_EN
    .err_cnt_clr(clr2), .err_cnt(cnt2),
`endif
    .out_valid(out_valid2), .data_out(data_out2), .k_out(k2),
    .code_err(ce2), .disp_err(de2), .rd_out(rd2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out1(input string tag, input vec_t v);
    chk({tag, "_ov"},   32'(out_valid1), 32'(1));
    chk({tag, "_data"}, 32'(data_out1),  32'(v.data));
    chk({tag, "_k"},    32'(k1),         32'(v.k));
    chk({tag, "_ce"},   32'(ce1),        32'(v.ce));
    chk({tag, "_de"},   32'(de1),        32'(v.de));
    chk({tag, "_rd"},   32'(rd1),        32'(v.rd));
  endtask

  // one isolated symbol: out_valid must be low after one edge, high after two
  task automatic apply1(input string tag, input vec_t v);
    @(negedge clk);
    in_valid1 = 1'b1;
    data_in1  = v.sym;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk({tag, "_lat"}, 32'(out_valid1), 32'(0));
    @(negedge clk);
    chk_out1(tag, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{10'h17C, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1};  // K28.5 at RD-
    vecs[1]  = '{10'h17C, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1};  // K28.5 RD- form at RD+
    vecs[2]  = '{10'h283, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};  // K28.5 RD+ form
    vecs[3]  = '{10'h0B9, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};  // D0.0
    vecs[4]  = '{10'h155, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0};  // D21.5
    vecs[5]  = '{10'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};  // all zeros
    vecs[6]  = '{10'h347, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1};  // D7.0 at RD-
    vecs[7]  = '{10'h247, 8'h27, 1'b0, 1'b0, 1'b1, 1'b1};  // 111000 at RD+
    vecs[8]  = '{10'h3A8, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b1};  // K23.7 at RD+
    vecs[9]  = '{10'h386, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};  // D0 with alt 7 (not allowed)
    vecs[10] = '{10'h04B, 8'hEB, 1'b0, 1'b0, 1'b0, 1'b0};  // D11.A7 at RD+
    vecs[11] = '{10'h3D5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};  // fghj=1111
    vecs[12] = '{10'h095, 8'h15, 1'b0, 1'b0, 1'b1, 1'b0};  // 4b -2 at RD-
    vecs[13] = '{10'h24F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};  // 111100 miss, +2 moves RD
    strm[0]  = '{10'h283, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
    strm[1]  = '{10'h17C, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1};
    strm[2]  = '{10'h283, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0};
    strm[3]  = '{10'h17C, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1};

    reset     = 1'b1;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    data_in1  = '0;
    data_in2  = '0;
`ifdef DEC8B10B_ERR_CNT_EN
    clr1 = 1'b0;
    clr2 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ov",   32'(out_valid1), 32'(0));
    chk("rst_data", 32'(data_out1),  32'(0));
    chk("rst_k",    32'(k1),         32'(0));
    chk("rst_ce",   32'(ce1),        32'(0));
    chk("rst_de",   32'(de1),        32'(0));
    chk("rst_rd",   32'(rd1),        32'(0));
    chk("rst_ov2",  32'(out_valid2), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < 14; i++) apply1($sformatf("v%0d", i), vecs[i]);

    // back-to-back symbols, one output per cycle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) chk_out1($sformatf("s%0d", i - 2), strm[i - 2]);
      if (i < 4) begin
        in_valid1 = 1'b1;
        data_in1  = strm[i].sym;
      end else begin
        in_valid1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("hold_ov",   32'(out_valid1), 32'(0));
    chk("hold_data", 32'(data_out1),  32'(8'hBC));
    chk("hold_rd",   32'(rd1),        32'(1));

    // two lanes: RD chains from lane 0 into lane 1
    @(negedge clk);
    in_valid2 = 1'b1;
    data_in2  = {10'h283, 10'h17C};
    @(negedge clk);
    data_in2  = {10'h17C, 10'h17C};
    @(negedge clk);
    in_valid2 = 1'b0;
    chk("l2a_ov",   32'(out_valid2), 32'(1));
    chk("l2a_data", 32'(data_out2),  32'(16'hBCBC));
    chk("l2a_k",    32'(k2),         32'(2'b11));
    chk("l2a_ce",   32'(ce2),        32'(2'b00));
    chk("l2a_de",   32'(de2),        32'(2'b00));
    chk("l2a_rd",   32'(rd2),        32'(0));
    @(negedge clk);
    chk("l2b_ov",   32'(out_valid2), 32'(1));
    chk("l2b_data", 32'(data_out2),  32'(16'hBCBC));
    chk("l2b_de",   32'(de2),        32'(2'b10));
    chk("l2b_ce",   32'(ce2),        32'(2'b00));
    chk("l2b_rd",   32'(rd2),        32'(1));
`ifdef DEC8B10B_ERR_CNT_EN
    chk("l2_cnt",   32'(cnt2),       32'(1));
`endif

    // reset while a symbol is in flight flushes it and restores RD_INIT
    @(negedge clk);
    in_valid1 = 1'b1;
    data_in1  = 10'h17C;
    @(negedge clk);
    in_valid1 = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    chk("mrst_ov",   32'(out_valid1), 32'(0));
    chk("mrst_rd",   32'(rd1),        32'(0));
    chk("mrst_data", 32'(data_out1),  32'(0));
    chk("mrst_rd2",  32'(rd2),        32'(0));
    @(negedge clk);
    chk("mrst_flush", 32'(out_valid1), 32'(0));

`ifdef DEC8B10B_ERR_CNT_EN
    chk("cnt_rst", 32'(cnt1), 32'(0));
    for (int i = 0; i < 3; i++) apply1($sformatf("c%0d", i), vecs[5]);
    chk("cnt_3", 32'(cnt1), 32'(3));
    @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("cnt_clr", 32'(cnt1), 32'(0));
    // clear coincides with an errored symbol reaching stage 2
    in_valid1 = 1'b1;
    data_in1  = 10'h000;
    @(negedge clk);
    in_valid1 = 1'b0;
    clr1      = 1'b1;
    @(negedge clk);
    clr1      = 1'b0;
    chk("cnt_clr_wins_ov", 32'(out_valid1), 32'(1));
    chk("cnt_clr_wins",    32'(cnt1),       32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
